// File: rtl/reg_bus_sequencer_pkg.sv
// Shared types and helpers for the register-bus transfer sequencer.
package reg_bus_sequencer_pkg;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StDrive,
    StCapture,
    StAck
  } state_e;

  localparam logic OP_MOVE = 1'b0;
  localparam logic OP_ALU  = 1'b1;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned clog2_min1(int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/reg_bus_sequencer_if.sv
// Request side and register-file control side of the transfer sequencer.
interface reg_bus_sequencer_if
  import reg_bus_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned IDX_W    = clog2_min1(NUM_REGS)
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       req_op;
  logic [NUM_REQ*IDX_W-1:0] req_src_a;
  logic [NUM_REQ*IDX_W-1:0] req_src_b;
  logic [NUM_REQ*IDX_W-1:0] req_dst;

  logic [NUM_REGS-1:0]      en_out_a;
  logic [NUM_REGS-1:0]      en_out_b;
  logic [NUM_REGS-1:0]      en_in;
  logic                     alu_sel;
  logic                     regs_clear_n;
  logic                     busy;
  logic [NUM_REQ-1:0]       done;
  logic                     err;

  // Sequencer side.
  modport master (
    input  req, req_op, req_src_a, req_src_b, req_dst,
    output en_out_a, en_out_b, en_in, alu_sel, regs_clear_n, busy, done, err
  );

  // Requesters plus register file side.
  modport slave (
    output req, req_op, req_src_a, req_src_b, req_dst,
    input  en_out_a, en_out_b, en_in, alu_sel, regs_clear_n, busy, done, err
  );

endinterface

// File: rtl/reg_bus_sequencer_rr_arbiter.sv
// Round-robin arbiter; the priority pointer moves past the winner on advance.
module reg_bus_sequencer_rr_arbiter
  import reg_bus_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned REQ_W  = clog2_min1(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [REQ_W-1:0]   gnt_idx
);

  logic [REQ_W-1:0] ptr_q;

  // First requesting port at or after the pointer, wrapping around.
  always_comb begin
    logic             found;
    logic [REQ_W-1:0] cand;
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = REQ_W'((32'(ptr_q) + 32'(k)) % NUM_REQ);
      if (!found && req[cand]) begin
        found            = 1'b1;
        gnt_onehot[cand] = 1'b1;
        gnt_idx          = cand;
      end
    end
  end

  // Pointer register: next search starts one past the last winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (gnt_idx == REQ_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/reg_bus_sequencer.sv
// Sequences MOVE / ALU transfers over the shared register-file buses.
module reg_bus_sequencer
  import reg_bus_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned NUM_REQ  = 4
) (
  input  logic               clk,
  input  logic               reset,
  reg_bus_sequencer_if.master bus
);

  localparam int unsigned IDX_W    = clog2_min1(NUM_REGS);
  localparam int unsigned REQ_W    = clog2_min1(NUM_REQ);
  // Only a non-power-of-two file can be addressed past its end.
  localparam bit          NON_POW2 = (32'd1 << IDX_W) != NUM_REGS;

  state_e               state_q, state_d;
  logic                 op_q, op_d;
  logic [IDX_W-1:0]     src_a_q, src_a_d;
  logic [IDX_W-1:0]     src_b_q, src_b_d;
  logic [IDX_W-1:0]     dst_q, dst_d;
  logic [NUM_REQ-1:0]   winner_q, winner_d;
  logic                 bad_q, bad_d;

  logic [NUM_REGS-1:0]  en_out_a_q, en_out_a_d;
  logic [NUM_REGS-1:0]  en_out_b_q, en_out_b_d;
  logic [NUM_REGS-1:0]  en_in_q, en_in_d;
  logic                 alu_sel_q, alu_sel_d;
  logic                 clear_n_q, clear_n_d;
  logic                 busy_q, busy_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 err_q, err_d;

  logic [NUM_REQ-1:0]   gnt_onehot;
  logic [REQ_W-1:0]     gnt_idx;
  logic                 advance;
  logic                 sel_op;
  logic [IDX_W-1:0]     sel_a, sel_b, sel_dst;
  logic                 sel_bad;

  function automatic logic [NUM_REGS-1:0] idx_onehot(logic [IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REGS; i++) oh[i] = (idx == IDX_W'(i));
    return oh;
  endfunction

  reg_bus_sequencer_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        (bus.req),
    .advance    (advance),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx)
  );

  // Mux the winning requester's fields and check them against the file size.
  always_comb begin
    sel_op  = 1'b0;
    sel_a   = '0;
    sel_b   = '0;
    sel_dst = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == REQ_W'(i)) begin
        sel_op  = bus.req_op[i];
        sel_a   = bus.req_src_a[i*IDX_W +: IDX_W];
        sel_b   = bus.req_src_b[i*IDX_W +: IDX_W];
        sel_dst = bus.req_dst[i*IDX_W +: IDX_W];
      end
    end
    sel_bad = NON_POW2 && ((32'(sel_a) >= NUM_REGS) || (32'(sel_dst) >= NUM_REGS) ||
                           ((sel_op == OP_ALU) && (32'(sel_b) >= NUM_REGS)));
  end

  // Next state, latch of the granted request, and next values of the output flops.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src_a_d    = src_a_q;
    src_b_d    = src_b_q;
    dst_d      = dst_q;
    winner_d   = winner_q;
    bad_d      = bad_q;
    advance    = 1'b0;
    en_out_a_d = '0;
    en_out_b_d = '0;
    en_in_d    = '0;
    alu_sel_d  = 1'b0;

    unique case (state_q)
      StInit:    state_d = StIdle;
      StIdle: begin
        if (|bus.req) begin
          advance  = 1'b1;
          op_d     = sel_op;
          src_a_d  = sel_a;
          src_b_d  = sel_b;
          dst_d    = sel_dst;
          winner_d = gnt_onehot;
          bad_d    = sel_bad;
          state_d  = sel_bad ? StAck : StDrive;
        end
      end
      StDrive:   state_d = StCapture;
      StCapture: state_d = StAck;
      StAck:     state_d = StIdle;
      default:   state_d = StInit;
    endcase

    // Outputs are computed from the next state so they leave a flop directly.
    if (state_d == StDrive || state_d == StCapture) begin
      en_out_a_d = idx_onehot(src_a_d);
      if (op_d == OP_ALU) en_out_b_d = idx_onehot(src_b_d);
      alu_sel_d = op_d;
    end
    if (state_d == StCapture) en_in_d = idx_onehot(dst_d);
    busy_d    = (state_d == StDrive) || (state_d == StCapture) || (state_d == StAck);
    done_d    = (state_d == StAck) ? winner_d : '0;
    err_d     = (state_d == StAck) && bad_d;
    clear_n_d = (state_d != StInit);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StInit;
      op_q       <= OP_MOVE;
      src_a_q    <= '0;
      src_b_q    <= '0;
      dst_q      <= '0;
      winner_q   <= '0;
      bad_q      <= 1'b0;
      en_out_a_q <= '0;
      en_out_b_q <= '0;
      en_in_q    <= '0;
      alu_sel_q  <= 1'b0;
      clear_n_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src_a_q    <= src_a_d;
      src_b_q    <= src_b_d;
      dst_q      <= dst_d;
      winner_q   <= winner_d;
      bad_q      <= bad_d;
      en_out_a_q <= en_out_a_d;
      en_out_b_q <= en_out_b_d;
      en_in_q    <= en_in_d;
      alu_sel_q  <= alu_sel_d;
      clear_n_q  <= clear_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.en_out_a     = en_out_a_q;
  assign bus.en_out_b     = en_out_b_q;
  assign bus.en_in        = en_in_q;
  assign bus.alu_sel      = alu_sel_q;
  assign bus.regs_clear_n = clear_n_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Scoreboard bench: stimulus queues expected bus states and completions,
// a negedge monitor pops and compares them.
module tb_reg_bus_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   started = 1'b0;
  bit   finish_flag = 1'b0;

  typedef struct {
    int         cyc;
    bit         d6;
    logic [7:0] ea, eb, ei;
    logic       alu, busy, clrn;
  } snap_t;

  typedef struct {
    int         cyc;
    logic [3:0] done;
    logic       err;
  } dn_t;

  snap_t snap_q[$];
  dn_t   dn8_q[$];
  dn_t   dn6_q[$];

  reg_bus_sequencer_if #(.NUM_REGS(8), .NUM_REQ(4)) bus8 ();
  reg_bus_sequencer_if #(.NUM_REGS(6), .NUM_REQ(4)) bus6 ();

  reg_bus_sequencer #(.NUM_REGS(8), .NUM_REQ(4)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  reg_bus_sequencer #(.NUM_REGS(6), .NUM_REQ(4)) dut6 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus6)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus helpers ----------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap(input int c, input bit d6, input logic [7:0] ea, input logic [7:0] eb,
                      input logic [7:0] ei, input logic alu, input logic busy,
                      input logic clrn);
    snap_t s;
    s.cyc = c; s.d6 = d6; s.ea = ea; s.eb = eb; s.ei = ei;
    s.alu = alu; s.busy = busy; s.clrn = clrn;
    snap_q.push_back(s);
  endtask

  task automatic push_dn(input bit d6, input int c, input logic [3:0] d, input logic e);
    dn_t x;
    x.cyc = c; x.done = d; x.err = e;
    if (d6) dn6_q.push_back(x);
    else dn8_q.push_back(x);
  endtask

  task automatic set_fields(input bit d6, input int i, input logic op, input logic [2:0] a,
                            input logic [2:0] b, input logic [2:0] d);
    if (d6) begin
      bus6.req_op[i] = op;
      bus6.req_src_a[i*3 +: 3] = a;
      bus6.req_src_b[i*3 +: 3] = b;
      bus6.req_dst[i*3 +: 3] = d;
    end else begin
      bus8.req_op[i] = op;
      bus8.req_src_a[i*3 +: 3] = a;
      bus8.req_src_b[i*3 +: 3] = b;
      bus8.req_dst[i*3 +: 3] = d;
    end
  endtask

  // Holds reset two edges; expects INIT (clear low) for one cycle after release.
  task automatic do_reset();
    int r;
    r = cyc;
    snap(r + 1, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    snap(r + 2, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    snap(r + 3, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    bus8.req = '0;
    bus6.req = '0;
    wait_neg(2);
    reset = 1'b0;
    wait_neg(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    bus8.req = '0; bus8.req_op = '0; bus8.req_src_a = '0; bus8.req_src_b = '0;
    bus8.req_dst = '0;
    bus6.req = '0; bus6.req_op = '0; bus6.req_src_a = '0; bus6.req_src_b = '0;
    bus6.req_dst = '0;
    @(negedge clk);
    started = 1'b1;
    do_reset();

    // Single MOVE: requester 0, r3 -> r5.
    k = cyc;
    set_fields(0, 0, 1'b0, 3'd3, 3'd0, 3'd5);
    bus8.req = 4'b0001;
    push_dn(0, k + 3, 4'b0001, 1'b0);
    snap(k + 1, 0, 8'h08, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    snap(k + 2, 0, 8'h08, 8'h00, 8'h20, 1'b0, 1'b1, 1'b1);
    snap(k + 3, 0, 8'h00, 8'h00, 8'h00, 1'bx, 1'b1, 1'b1);
    snap(k + 4, 0, 8'h00, 8'h00, 8'h00, 1'bx, 1'b0, 1'b1);
    wait_neg(3);
    bus8.req = '0;
    wait_neg(1);

    // ALU: requester 2, a=b=dst=1; fields scrambled and req dropped after latch.
    k = cyc;
    set_fields(0, 2, 1'b1, 3'd1, 3'd1, 3'd1);
    bus8.req = 4'b0100;
    push_dn(0, k + 3, 4'b0100, 1'b0);
    snap(k + 1, 0, 8'h02, 8'h02, 8'h00, 1'b1, 1'b1, 1'b1);
    snap(k + 2, 0, 8'h02, 8'h02, 8'h02, 1'b1, 1'b1, 1'b1);
    snap(k + 3, 0, 8'h00, 8'h00, 8'h00, 1'bx, 1'b1, 1'b1);
    wait_neg(1);
    set_fields(0, 2, 1'b0, 3'd6, 3'd5, 3'd4);
    bus8.req = '0;
    wait_neg(3);

    // ALU: requester 3, a=6 b=2 dst=6 (dst aliases src_a).
    k = cyc;
    set_fields(0, 3, 1'b1, 3'd6, 3'd2, 3'd6);
    bus8.req = 4'b1000;
    push_dn(0, k + 3, 4'b1000, 1'b0);
    snap(k + 1, 0, 8'h40, 8'h04, 8'h00, 1'b1, 1'b1, 1'b1);
    snap(k + 2, 0, 8'h40, 8'h04, 8'h40, 1'b1, 1'b1, 1'b1);
    wait_neg(3);
    bus8.req = '0;
    wait_neg(1);

    // All four held: grants 0,1,2,3,0 spaced four cycles apart.
    do_reset();
    k = cyc;
    for (int i = 0; i < 4; i++) set_fields(0, i, 1'b0, 3'(i), 3'd0, 3'(i + 4));
    bus8.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      int i;
      i = j % 4;
      push_dn(0, k + 3 + 4 * j, 4'(1 << i), 1'b0);
      snap(k + 1 + 4 * j, 0, 8'(1 << i), 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
      snap(k + 2 + 4 * j, 0, 8'(1 << i), 8'h00, 8'(1 << (i + 4)), 1'b0, 1'b1, 1'b1);
    end
    wait_neg(19);
    bus8.req = '0;
    wait_neg(1);

    // Reset during CAPTURE of requester 1; afterwards arbitration restarts at 0.
    k = cyc;
    set_fields(0, 0, 1'b0, 3'd0, 3'd0, 3'd1);
    set_fields(0, 1, 1'b0, 3'd2, 3'd0, 3'd3);
    bus8.req = 4'b0011;
    snap(k + 1, 0, 8'h04, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    snap(k + 2, 0, 8'h04, 8'h00, 8'h08, 1'b0, 1'b1, 1'b1);
    snap(k + 3, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    wait_neg(2);
    reset = 1'b1;
    wait_neg(1);
    reset = 1'b0;
    snap(k + 4, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    snap(k + 5, 0, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    snap(k + 6, 0, 8'h01, 8'h00, 8'h02, 1'b0, 1'b1, 1'b1);
    snap(k + 7, 0, 8'h00, 8'h00, 8'h00, 1'bx, 1'b1, 1'b1);
    snap(k + 9, 0, 8'h04, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    snap(k + 10, 0, 8'h04, 8'h00, 8'h08, 1'b0, 1'b1, 1'b1);
    push_dn(0, k + 7, 4'b0001, 1'b0);
    push_dn(0, k + 11, 4'b0010, 1'b0);
    wait_neg(8);
    bus8.req = '0;
    wait_neg(1);

    // Six-register file: dst=7 squashed, ALU src_b=6 squashed.
    k = cyc;
    set_fields(1, 0, 1'b0, 3'd2, 3'd0, 3'd7);
    bus6.req = 4'b0001;
    push_dn(1, k + 1, 4'b0001, 1'b1);
    snap(k + 1, 1, 8'h00, 8'h00, 8'h00, 1'bx, 1'b1, 1'b1);
    snap(k + 2, 1, 8'h00, 8'h00, 8'h00, 1'bx, 1'b0, 1'b1);
    wait_neg(1);
    bus6.req = '0;
    wait_neg(1);

    k = cyc;
    set_fields(1, 1, 1'b1, 3'd5, 3'd6, 3'd0);
    bus6.req = 4'b0010;
    push_dn(1, k + 1, 4'b0010, 1'b1);
    snap(k + 1, 1, 8'h00, 8'h00, 8'h00, 1'bx, 1'b1, 1'b1);
    snap(k + 2, 1, 8'h00, 8'h00, 8'h00, 1'bx, 1'b0, 1'b1);
    wait_neg(1);
    bus6.req = '0;
    wait_neg(1);

    // MOVE with out-of-range src_b is legal: src_b is unused.
    k = cyc;
    set_fields(1, 2, 1'b0, 3'd5, 3'd7, 3'd0);
    bus6.req = 4'b0100;
    push_dn(1, k + 3, 4'b0100, 1'b0);
    snap(k + 1, 1, 8'h20, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    snap(k + 2, 1, 8'h20, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1);
    snap(k + 3, 1, 8'h00, 8'h00, 8'h00, 1'bx, 1'b1, 1'b1);
    wait_neg(3);
    bus6.req = '0;
    wait_neg(2);

    finish_flag = 1'b1;
  end

  // ---------------- monitor ----------------
  task automatic chk_snap(input snap_t s);
    logic [7:0] ea, eb, ei;
    logic       alu, busy, clrn;
    if (s.d6) begin
      ea = {2'b00, bus6.en_out_a}; eb = {2'b00, bus6.en_out_b}; ei = {2'b00, bus6.en_in};
      alu = bus6.alu_sel; busy = bus6.busy; clrn = bus6.regs_clear_n;
    end else begin
      ea = bus8.en_out_a; eb = bus8.en_out_b; ei = bus8.en_in;
      alu = bus8.alu_sel; busy = bus8.busy; clrn = bus8.regs_clear_n;
    end
    n_checks++;
    if (s.cyc != cyc || ea !== s.ea || eb !== s.eb || ei !== s.ei ||
        (s.alu !== 1'bx && alu !== s.alu) || busy !== s.busy || clrn !== s.clrn) begin
      n_fail++;
      $display("FAIL bus_state dut%0d cyc %0d: got ea=%h eb=%h ei=%h alu=%b busy=%b clr_n=%b; want cyc %0d ea=%h eb=%h ei=%h alu=%b busy=%b clr_n=%b",
               s.d6 ? 6 : 8, cyc, ea, eb, ei, alu, busy, clrn,
               s.cyc, s.ea, s.eb, s.ei, s.alu, s.busy, s.clrn);
    end
  endtask

  task automatic chk_done(input bit d6, input logic [3:0] d, input logic e);
    dn_t x;
    bit  empty;
    n_checks++;
    empty = d6 ? (dn6_q.size() == 0) : (dn8_q.size() == 0);
    if (empty) begin
      n_fail++;
      $display("FAIL done dut%0d: unexpected done=%b err=%b at cyc %0d", d6 ? 6 : 8, d, e, cyc);
      return;
    end
    if (d6) x = dn6_q.pop_front();
    else x = dn8_q.pop_front();
    if (d !== x.done || e !== x.err || cyc != x.cyc) begin
      n_fail++;
      $display("FAIL done dut%0d: got done=%b err=%b cyc %0d; want done=%b err=%b cyc %0d",
               d6 ? 6 : 8, d, e, cyc, x.done, x.err, x.cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        // At most one driver / loader per bus, every cycle.
        n_checks++;
        if ($countones(bus8.en_out_a) > 1 || $countones(bus8.en_out_b) > 1 ||
            $countones(bus8.en_in) > 1 || $countones(bus6.en_out_a) > 1 ||
            $countones(bus6.en_out_b) > 1 || $countones(bus6.en_in) > 1) begin
          n_fail++;
          $display("FAIL exclusive cyc %0d: got a=%h b=%h in=%h / a=%h b=%h in=%h; want <=1 hot",
                   cyc, bus8.en_out_a, bus8.en_out_b, bus8.en_in,
                   bus6.en_out_a, bus6.en_out_b, bus6.en_in);
        end
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) chk_snap(snap_q.pop_front());
        if (bus8.done != 4'b0000 || bus8.err) chk_done(0, bus8.done, bus8.err);
        if (bus6.done != 4'b0000 || bus6.err) chk_done(1, bus6.done, bus6.err);
        if (cyc > 2000) begin
          n_fail++;
          $display("FAIL timeout: got cyc %0d, want end before 2000", cyc);
          $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
          $finish;
        end
        if (finish_flag) begin
          n_checks++;
          if (snap_q.size() != 0 || dn8_q.size() != 0 || dn6_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending: got %0d/%0d/%0d outstanding expectations, want 0/0/0",
                     snap_q.size(), dn8_q.size(), dn6_q.size());
          end
          $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
          $finish;
        end
      end
    end
  end

endmodule
